// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } resp_state_e;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      MEM_B:   be = 4'b0001 << addr_lo;
      MEM_H:   be = 4'b0011 << addr_lo;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Word-wide RAM with per-byte write enables, synchronous write and combinational read.
module bram_be #(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core data-memory port: fixed-latency RAM access with byte-lane
// stores and fault reporting over valid/ready request and response channels.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  CNT_LOAD = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  resp_state_e state, next_state;
  logic [2:0]  cnt, cnt_next;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        eff_we;
  logic [1:0]  eff_size;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;

  logic          accept;
  logic          execute;
  logic [31:0]   off;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic [AW-1:0] idx;
  logic [31:0]   mem_rdata;
  logic          mem_we;

  assign req_ready = (state == S_IDLE) && reset;
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            next_state = S_RESP;
          end else begin
            next_state = S_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 3'd0) next_state = S_RESP;
        else             cnt_next   = cnt - 3'd1;
      end
      S_RESP: begin
        if (rsp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // With zero latency the access happens on the accept edge itself, before the
  // latches hold the request, so the live request fields are used while in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      eff_we    = req_we;
      eff_size  = req_size;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end else begin
      eff_we    = lat_we;
      eff_size  = lat_size;
      eff_addr  = lat_addr;
      eff_wdata = lat_wdata;
    end
  end

  assign execute = (state != S_RESP) && (next_state == S_RESP);
  assign off     = eff_addr - BASE_ADDR;
  assign idx     = off[AW+1:2];
  assign be      = be_gen(eff_size, eff_addr[1:0]);

  always_comb begin
    err = 1'b0;
    if (eff_size == 2'b11)                              err = 1'b1;
    if ((eff_size == MEM_H) && eff_addr[0])             err = 1'b1;
    if ((eff_size == MEM_W) && (eff_addr[1:0] != 2'b00)) err = 1'b1;
    if ({1'b0, off} >= LIMIT)                           err = 1'b1;
  end

  always_comb begin
    case (eff_size)
      MEM_B:   lane_data = {4{eff_wdata[7:0]}};
      MEM_H:   lane_data = {2{eff_wdata[15:0]}};
      default: lane_data = eff_wdata;
    endcase
  end

  assign mem_we = execute && eff_we && !err;

  bram_be #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bram (
    .clk  (clk),
    .we   (mem_we),
    .be   (be),
    .idx  (idx),
    .wdata(lane_data),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (accept) begin
        lat_we    <= req_we;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (execute) begin
        rsp_rdata <= (err || eff_we) ? '0 : mem_rdata;
        rsp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        s_valid, s_we, s_rsp_ready;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign req_valid_a = s_valid && !sel;
  assign req_valid_b = s_valid && sel;
  assign rsp_ready_a = s_rsp_ready && !sel;
  assign rsp_ready_b = s_rsp_ready && sel;

  assign o_req_ready = sel ? req_ready_b : req_ready_a;
  assign o_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign o_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
  assign o_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

  data_mem_responder #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (2)
  ) dut_a (
    .clk      (clk),
    .reset    (rst_n),
    .req_valid(req_valid_a),
    .req_ready(req_ready_a),
    .req_we   (s_we),
    .req_size (s_size),
    .req_addr (s_addr),
    .req_wdata(s_wdata),
    .rsp_valid(rsp_valid_a),
    .rsp_ready(rsp_ready_a),
    .rsp_rdata(rsp_rdata_a),
    .rsp_err  (rsp_err_a)
  );

  data_mem_responder #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h8000_0000),
    .LATENCY    (0)
  ) dut_b (
    .clk      (clk),
    .reset    (rst_n),
    .req_valid(req_valid_b),
    .req_ready(req_ready_b),
    .req_we   (s_we),
    .req_size (s_size),
    .req_addr (s_addr),
    .req_wdata(s_wdata),
    .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b),
    .rsp_err  (rsp_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance, checking latency and response.
  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int lat;
    lat = sel ? 0 : 2;
    @(negedge clk);
    s_we = we; s_size = size; s_addr = addr; s_wdata = wdata; s_valid = 1'b1;
    #1 check({tag, ".req_ready"}, o_req_ready, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check({tag, ".wait_valid"}, o_rsp_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, ".rsp_valid"}, o_rsp_valid, 1);
    check({tag, ".rdata"}, o_rsp_rdata, exp_rdata);
    check({tag, ".err"}, o_rsp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, o_rsp_valid, 1);
      check({tag, ".hold_rdata"}, o_rsp_rdata, exp_rdata);
      check({tag, ".hold_err"}, o_rsp_err, exp_err);
      check({tag, ".hold_req_ready"}, o_req_ready, 0);
    end
    s_rsp_ready = 1'b1;
    #1 check({tag, ".resp_req_ready"}, o_req_ready, 0);
    @(posedge clk);
    #1 s_rsp_ready = 1'b0;
    check({tag, ".post_valid"}, o_rsp_valid, 0);
    check({tag, ".post_req_ready"}, o_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 1'b0; s_valid = 1'b0; s_we = 1'b0; s_rsp_ready = 1'b0;
    s_size = 2'b00; s_addr = '0; s_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a.req_ready", req_ready_a, 0);
    check("rst_a.rsp_valid", rsp_valid_a, 0);
    check("rst_a.rdata", rsp_rdata_a, 32'h0);
    check("rst_a.err", rsp_err_a, 0);
    check("rst_b.req_ready", req_ready_b, 0);
    check("rst_b.rsp_valid", rsp_valid_b, 0);
    rst_n = 1'b1;

    // LATENCY=2 instance
    sel = 1'b0;
    txn("st_w",      1'b1, 2'b10, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
    txn("ld_w",      1'b0, 2'b10, 32'h8000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    txn("st_b",      1'b1, 2'b00, 32'h8000_0001, 32'hFFFF_FF55, 32'h0,         1'b0, 0);
    txn("ld_after_b",1'b0, 2'b10, 32'h8000_0000, 32'h0,         32'hDEAD_55EF, 1'b0, 0);
    txn("st_h",      1'b1, 2'b01, 32'h8000_0002, 32'hABCD_1234, 32'h0,         1'b0, 0);
    txn("ld_after_h",1'b0, 2'b10, 32'h8000_0000, 32'h0,         32'h1234_55EF, 1'b0, 0);
    txn("ld_h_mis",  1'b0, 2'b01, 32'h8000_0003, 32'h0,         32'h0,         1'b1, 0);
    txn("st_w_mis",  1'b1, 2'b10, 32'h8000_0002, 32'hFFFF_FFFF, 32'h0,         1'b1, 0);
    txn("ld_unchg",  1'b0, 2'b10, 32'h8000_0000, 32'h0,         32'h1234_55EF, 1'b0, 0);
    txn("ld_below",  1'b0, 2'b10, 32'h7FFF_FFFC, 32'h0,         32'h0,         1'b1, 0);
    txn("ld_above",  1'b0, 2'b10, 32'h8000_4000, 32'h0,         32'h0,         1'b1, 0);
    txn("ld_size11", 1'b0, 2'b11, 32'h8000_0000, 32'h0,         32'h0,         1'b1, 0);
    txn("st_last",   1'b1, 2'b10, 32'h8000_3FFC, 32'hA5A5_5A5A, 32'h0,         1'b0, 0);
    txn("ld_last",   1'b0, 2'b10, 32'h8000_3FFC, 32'h0,         32'hA5A5_5A5A, 1'b0, 0);
    txn("ld_hold",   1'b0, 2'b10, 32'h8000_0000, 32'h0,         32'h1234_55EF, 1'b0, 5);
    txn("ld_b2b",    1'b0, 2'b10, 32'h8000_3FFC, 32'h0,         32'hA5A5_5A5A, 1'b0, 0);
    txn("st_pre",    1'b1, 2'b10, 32'h8000_0010, 32'hCAFE_F00D, 32'h0,         1'b0, 0);
    txn("ld_pre",    1'b0, 2'b10, 32'h8000_0010, 32'h0,         32'hCAFE_F00D, 1'b0, 0);

    // Store interrupted by reset while waiting
    @(negedge clk);
    s_we = 1'b1; s_size = 2'b10; s_addr = 32'h8000_0010; s_wdata = 32'h1234_5678; s_valid = 1'b1;
    #1 check("rstw_a.req_ready", o_req_ready, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check("rstw_a.wait_valid", o_rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    check("rstw_a.rsp_valid", o_rsp_valid, 0);
    check("rstw_a.rdata", o_rsp_rdata, 32'h0);
    check("rstw_a.err", o_rsp_err, 0);
    check("rstw_a.req_ready", o_req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn("ld_after_rst_a", 1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

    // LATENCY=0 instance
    sel = 1'b1;
    txn("b_st_w",    1'b1, 2'b10, 32'h8000_0010, 32'hCAFE_F00D, 32'h0,         1'b0, 0);
    txn("b_st_b",    1'b1, 2'b00, 32'h8000_0012, 32'h0000_0077, 32'h0,         1'b0, 0);
    txn("b_ld_w",    1'b0, 2'b10, 32'h8000_0010, 32'h0,         32'hCA77_F00D, 1'b0, 0);
    txn("b_ld_h_mis",1'b0, 2'b01, 32'h8000_0011, 32'h0,         32'h0,         1'b1, 0);
    txn("b_ld_hold", 1'b0, 2'b10, 32'h8000_0010, 32'h0,         32'hCA77_F00D, 1'b0, 3);

    // Store presented while reset is asserted is never accepted
    @(negedge clk);
    s_we = 1'b1; s_size = 2'b10; s_addr = 32'h8000_0010; s_wdata = 32'h1234_5678; s_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstw_b.req_ready", o_req_ready, 0);
    check("rstw_b.rdata", o_rsp_rdata, 32'h0);
    @(posedge clk);
    #1 check("rstw_b.rsp_valid", o_rsp_valid, 0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    txn("b_ld_after_rst", 1'b0, 2'b10, 32'h8000_0010, 32'h0, 32'hCA77_F00D, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
